light_sequencer: RTL and testbench
==================================

Name: light_sequencer

Overview:
- Per-approach phase sequencer. Produces the 2-bit light code consumed by the `semaforo` decoders, so it is the transmitting end of that interface.
- The central `fsm` issues go/stop requests. This block enforces minimum green, yellow and all-red clearance times, then acknowledges.
- One instance per approach (TH, NN, NS), clocked from CLK_10k.

Parameters:
- CLK_HZ, 10000, clock cycles per one-second tick.
- GREEN_MIN_S, 5, minimum green duration in seconds.
- YELLOW_S, 3, yellow duration in seconds.
- CLEAR_S, 1, all-red clearance duration in seconds after yellow.
- SEC_W, 8, width of the seconds counter. All *_S parameters must be < 2^SEC_W.

Ports:
- clk  input  1  system clock (CLK_10k).
- clock_reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = normal sequencing; 0 = disabled mode.
- req_go  input  1  level; request green. Sampled only in state RED.
- req_stop  input  1  level; request red. Sampled only in state GREEN.
- light  output  2  light code to `semaforo`.
- is_red  output  1  high in RED and ALL_RED.
- ack  output  1  one-cycle pulse on entering GREEN.
- done  output  1  one-cycle pulse on entering RED from ALL_RED.

Behaviour:
- Light codes: 2'b00 RED, 2'b01 GREEN, 2'b10 YELLOW, 2'b11 OFF.
- Reset (synchronous; wins over every other input):
  - state RED, light 00, is_red 1, ack 0, done 0.
  - Prescaler and seconds counter cleared.
  - Reset during any state, including mid-YELLOW, returns to RED on the next edge.
- Timing:
  - Prescaler counts 0..CLK_HZ-1 and pulses tick when it wraps to 0.
  - Seconds counter increments on each tick and saturates at all-ones.
  - Both counters clear on every state entry, so a phase of N seconds lasts exactly N*CLK_HZ cycles.
- All outputs are registered. light reflects the new state in the cycle after the transition edge.
- States and transitions:
  - RED: if enable && req_go, go to GREEN next cycle; ack=1 for that one cycle.
  - GREEN: req_stop is latched into stop_pend if it arrives before GREEN_MIN_S has elapsed. When secs >= GREEN_MIN_S and (req_stop || stop_pend), go to YELLOW.
  - YELLOW: when secs == YELLOW_S, go to ALL_RED (light 00).
  - ALL_RED: when secs == CLEAR_S, go to RED; done=1 for one cycle.
  - DISABLED: entered from any state when enable=0, on the next edge. Leaving is only to RED, when enable returns to 1; the leave is not acknowledged.
- Simultaneous or overlapping requests:
  - req_go and req_stop both high in RED: go wins; stop is evaluated only in GREEN.
  - req_go is ignored in GREEN, YELLOW and ALL_RED and is not queued.
  - req_stop is ignored outside GREEN.
  - stop_pend clears on entering YELLOW or on reset.
- CLEAR_S = 0: ALL_RED lasts one cycle, then RED.
- GREEN_MIN_S = 0: a stop present in GREEN takes effect on the next cycle.

Optional Feature:
- Macro: LIGHT_SEQUENCER_FLASH_EN.
- Defined: DISABLED flashes. light toggles between YELLOW and OFF on every tick, starting at YELLOW on entry; is_red=0.
- Not defined: DISABLED holds light=RED and is_red=1. No flash logic is synthesized.

Decomposition:
- Shared package `traffic_pkg` holds:
  - light-code localparams: LIGHT_RED, LIGHT_GREEN, LIGHT_YELLOW, LIGHT_OFF;
  - the state encoding: RED, GREEN, YELLOW, ALL_RED, DISABLED.
- The package is reused by `fsm` and `semaforo`.
- One sub-module: `second_tick` (CLK_HZ prescaler with synchronous clear input, outputs a tick pulse).

Test Plan:
All runs use CLK_HZ=10, GREEN_MIN_S=3, YELLOW_S=2, CLEAR_S=1.
1. Assert clock_reset for 2 cycles -> light=00, is_red=1, ack=0, done=0.
2. From RED, req_go=1 -> light=01 one cycle later; ack high for exactly 1 cycle; is_red=0.
3. req_stop pulse 5 cycles after GREEN entry -> GREEN held until cycle 30; YELLOW for 20 cycles; ALL_RED for 10 cycles; then done pulses once and light=00.
4. req_stop held at cycle 40 of GREEN -> YELLOW on the next cycle. req_go asserted during YELLOW -> no effect; RED is reached with done.
5. Assert clock_reset at cycle 7 of YELLOW -> light=00, counters 0 next cycle. A following req_go gives a full GREEN_MIN_S green.
6. enable=0 in GREEN:
   - with LIGHT_SEQUENCER_FLASH_EN: light alternates 10/11 every 10 cycles;
   - without it: light=00 steady.
   - Either way, enable=1 returns to RED with no ack and no done.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-light types: the 2-bit light code and the approach state encoding.
// Used by light_sequencer, fsm and semaforo.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  typedef enum logic [2:0] {
    RED      = 3'd0,
    GREEN    = 3'd1,
    YELLOW   = 3'd2,
    ALL_RED  = 3'd3,
    DISABLED = 3'd4
  } state_t;

  // Steady light code for a state; the flashing DISABLED pattern is handled by the sequencer.
  function automatic logic [1:0] light_of(input state_t s);
    case (s)
      GREEN:   light_of = LIGHT_GREEN;
      YELLOW:  light_of = LIGHT_YELLOW;
      default: light_of = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/second_tick.sv
// CLK_HZ prescaler: counts 0..CLK_HZ-1 and raises o_tick in the cycle whose edge wraps it to 0.
// i_clear restarts the count so a phase always begins on a full second.
module second_tick #(
  parameter int CLK_HZ = 10000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Per-approach phase sequencer: enforces minimum green, yellow and all-red clearance, drives semaforo.
// Define LIGHT_SEQUENCER_FLASH_EN to flash yellow/off while disabled instead of holding red.
module light_sequencer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ      = 10000,
  parameter int GREEN_MIN_S = 5,
  parameter int YELLOW_S    = 3,
  parameter int CLEAR_S     = 1,
  parameter int SEC_W       = 8
) (
  input  logic       clk,
  input  logic       clock_reset,
  input  logic       enable,
  input  logic       req_go,
  input  logic       req_stop,
  output logic [1:0] light,
  output logic       is_red,
  output logic       ack,
  output logic       done
);

  localparam logic [SEC_W-1:0] GREEN_MIN_C = SEC_W'(GREEN_MIN_S);
  localparam logic [SEC_W-1:0] YELLOW_C    = SEC_W'(YELLOW_S);
  localparam logic [SEC_W-1:0] CLEAR_C     = SEC_W'(CLEAR_S);

  state_t           r_state;
  logic [SEC_W-1:0] r_secs;
  logic             r_stop_pend;
  logic [1:0]       r_light;
  logic             r_is_red;
  logic             r_ack;
  logic             r_done;

  state_t           w_next;
  logic             w_enter;
  logic             w_tick;
  logic [SEC_W-1:0] w_secs_eff;

  second_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_second_tick (
    .clk     (clk),
    .i_rst   (clock_reset),
    .i_clear (w_enter),
    .o_tick  (w_tick)
  );

  // Seconds count as it will stand after this edge; comparing against it makes an
  // N-second phase last exactly N*CLK_HZ cycles (and a 0-second phase one cycle).
  always_comb begin
    w_secs_eff = r_secs;
    if (w_tick && (r_secs != {SEC_W{1'b1}})) begin
      w_secs_eff = r_secs + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = DISABLED;
    end else begin
      case (r_state)
        RED:      if (req_go) w_next = GREEN;
        GREEN:    if ((w_secs_eff >= GREEN_MIN_C) && (req_stop || r_stop_pend)) w_next = YELLOW;
        YELLOW:   if (w_secs_eff == YELLOW_C) w_next = ALL_RED;
        ALL_RED:  if (w_secs_eff == CLEAR_C) w_next = RED;
        DISABLED: w_next = RED;
        default:  w_next = RED;
      endcase
    end
  end

  assign w_enter = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (clock_reset) begin
      r_state     <= RED;
      r_secs      <= '0;
      r_stop_pend <= 1'b0;
      r_light     <= LIGHT_RED;
      r_is_red    <= 1'b1;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_secs  <= w_enter ? '0 : w_secs_eff;

      // A stop latched in GREEN must not survive a trip through DISABLED.
      if ((w_next == YELLOW) || (w_next == DISABLED)) begin
        r_stop_pend <= 1'b0;
      end else if ((r_state == GREEN) && req_stop) begin
        r_stop_pend <= 1'b1;
      end

      r_ack  <= (r_state == RED) && (w_next == GREEN);
      r_done <= (r_state == ALL_RED) && (w_next == RED);

`ifdef LIGHT_SEQUENCER_FLASH_EN
      if (w_next == DISABLED) begin
        r_is_red <= 1'b0;
        if (r_state != DISABLED) begin
          r_light <= LIGHT_YELLOW;
        end else if (w_tick) begin
          r_light <= (r_light == LIGHT_YELLOW) ? LIGHT_OFF : LIGHT_YELLOW;
        end
      end else begin
        r_light  <= light_of(w_next);
        r_is_red <= (w_next == RED) || (w_next == ALL_RED);
      end
`else
      r_light  <= light_of(w_next);
      r_is_red <= (w_next != GREEN) && (w_next != YELLOW);
`endif
    end
  end

  assign light  = r_light;
  assign is_red = r_is_red;
  assign ack    = r_ack;
  assign done   = r_done;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer (CLK_HZ=10, GREEN_MIN_S=3, YELLOW_S=2, CLEAR_S=1).
// Honours LIGHT_SEQUENCER_FLASH_EN for the disabled-mode expectations.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       clock_reset;
  logic       enable;
  logic       req_go;
  logic       req_stop;
  logic [1:0] light;
  logic       is_red;
  logic       ack;
  logic       done;

  int checks = 0;
  int errors = 0;

  light_sequencer #(
    .CLK_HZ      (10),
    .GREEN_MIN_S (3),
    .YELLOW_S    (2),
    .CLEAR_S     (1),
    .SEC_W       (8)
  ) dut (
    .clk         (clk),
    .clock_reset (clock_reset),
    .enable      (enable),
    .req_go      (req_go),
    .req_stop    (req_stop),
    .light       (light),
    .is_red      (is_red),
    .ack         (ack),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       go;
    logic       stop;
    logic [7:0] n;
    logic [1:0] light;
    logic       is_red;
    logic       ack;
    logic       done;
  } vec_t;

  typedef struct packed {
    logic [1:0] light;
    logic       is_red;
    logic       ack;
    logic       done;
    int         tag;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_GRN = 2'b01;
  localparam logic [1:0] L_YEL = 2'b10;
  localparam logic [1:0] L_OFF = 2'b11;

  task automatic add(input logic rst, input logic en, input logic go, input logic stop,
                     input int n, input logic [1:0] l, input logic ir, input logic a, input logic d);
    vec_t v;
    v.rst = rst; v.en = en; v.go = go; v.stop = stop; v.n = 8'(n);
    v.light = l; v.is_red = ir; v.ack = a; v.done = d;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, and check it one edge later.
  task automatic apply(input logic rst, input logic en, input logic go, input logic stop,
                       input logic [1:0] l, input logic ir, input logic a, input logic d,
                       input int tag);
    exp_t e;
    clock_reset = rst;
    enable      = en;
    req_go      = go;
    req_stop    = stop;
    e.light = l; e.is_red = ir; e.ack = a; e.done = d; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({light, is_red, ack, done} !== {e.light, e.is_red, e.ack, e.done}) begin
      errors++;
      $display("FAIL step%0d: got light=%b is_red=%b ack=%b done=%b, expected light=%b is_red=%b ack=%b done=%b",
               e.tag, light, is_red, ack, done, e.light, e.is_red, e.ack, e.done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] dis_l;
    logic       dis_r;
    clock_reset = 1'b1;
    enable      = 1'b1;
    req_go      = 1'b0;
    req_stop    = 1'b0;

    //   rst en go st  n   light  is_red ack done
    add(1, 1, 0, 0,  2, L_RED, 1, 0, 0);  // 0  reset
    add(0, 1, 1, 0,  1, L_GRN, 0, 1, 0);  // 1  go -> GREEN, ack
    add(0, 1, 0, 0,  4, L_GRN, 0, 0, 0);  // 2
    add(0, 1, 0, 1,  1, L_GRN, 0, 0, 0);  // 3  stop pulse at cycle 5
    add(0, 1, 0, 0, 24, L_GRN, 0, 0, 0);  // 4  held to 30 cycles
    add(0, 1, 0, 0, 20, L_YEL, 0, 0, 0);  // 5
    add(0, 1, 0, 0, 10, L_RED, 1, 0, 0);  // 6  all-red
    add(0, 1, 0, 0,  1, L_RED, 1, 0, 1);  // 7  done
    add(0, 1, 0, 0,  2, L_RED, 1, 0, 0);  // 8
    add(0, 1, 1, 0,  1, L_GRN, 0, 1, 0);  // 9
    add(0, 1, 0, 0, 39, L_GRN, 0, 0, 0);  // 10 no stop yet
    add(0, 1, 0, 1,  1, L_YEL, 0, 0, 0);  // 11 late stop: immediate
    add(0, 1, 0, 1,  2, L_YEL, 0, 0, 0);  // 12
    add(0, 1, 1, 0,  8, L_YEL, 0, 0, 0);  // 13 go ignored in yellow
    add(0, 1, 0, 0,  9, L_YEL, 0, 0, 0);  // 14
    add(0, 1, 0, 0, 10, L_RED, 1, 0, 0);  // 15
    add(0, 1, 0, 0,  1, L_RED, 1, 0, 1);  // 16
    add(0, 1, 0, 0,  3, L_RED, 1, 0, 0);  // 17 go was not queued
    add(0, 1, 1, 0,  1, L_GRN, 0, 1, 0);  // 18
    add(0, 1, 0, 1, 29, L_GRN, 0, 0, 0);  // 19
    add(0, 1, 0, 0,  7, L_YEL, 0, 0, 0);  // 20 pending stop still fires
    add(1, 1, 1, 0,  1, L_RED, 1, 0, 0);  // 21 reset mid-yellow beats go
    add(0, 1, 0, 0,  2, L_RED, 1, 0, 0);  // 22
    add(0, 1, 1, 1,  1, L_GRN, 0, 1, 0);  // 23 go wins over stop in RED
    add(0, 1, 0, 1, 29, L_GRN, 0, 0, 0);  // 24 full minimum green
    add(0, 1, 0, 1,  1, L_YEL, 0, 0, 0);  // 25
    add(0, 1, 0, 0, 19, L_YEL, 0, 0, 0);  // 26
    add(0, 1, 0, 0, 10, L_RED, 1, 0, 0);  // 27
    add(0, 1, 0, 0,  1, L_RED, 1, 0, 1);  // 28

    foreach (tbl[r]) begin
      for (int c = 0; c < int'(tbl[r].n); c++) begin
        apply(tbl[r].rst, tbl[r].en, tbl[r].go, tbl[r].stop,
              tbl[r].light, tbl[r].is_red, tbl[r].ack, tbl[r].done, r * 100 + c);
      end
      $display("row %0d: %0d cycles rst=%b en=%b go=%b stop=%b light=%b", r, tbl[r].n,
               tbl[r].rst, tbl[r].en, tbl[r].go, tbl[r].stop, tbl[r].light);
    end

`ifdef LIGHT_SEQUENCER_FLASH_EN
    dis_l = L_YEL;
    dis_r = 1'b0;
`else
    dis_l = L_RED;
    dis_r = 1'b1;
`endif

    // Disable from GREEN, run through several flash periods, then re-enable.
    apply(0, 1, 1, 0, L_GRN, 0, 1, 0, 5000);
    for (int c = 1; c < 5; c++) apply(0, 1, 0, 0, L_GRN, 0, 0, 0, 5000 + c);
    for (int k = 0; k < 25; k++) begin
      logic [1:0] exp_l;
`ifdef LIGHT_SEQUENCER_FLASH_EN
      exp_l = (((k / 10) % 2) == 0) ? L_YEL : L_OFF;
`else
      exp_l = L_RED;
`endif
      apply(0, 0, (k > 12), (k > 5), exp_l, dis_r, 0, 0, 6000 + k);
    end
    $display("disabled from GREEN: 25 cycles checked");
    apply(0, 1, 0, 0, L_RED, 1, 0, 0, 7000);
    apply(0, 1, 0, 0, L_RED, 1, 0, 0, 7001);
    $display("re-enable: RED without ack/done");

    // Leaving DISABLED goes to RED even with go high; go then acts from RED.
    apply(0, 0, 0, 0, dis_l, dis_r, 0, 0, 8000);
    apply(0, 1, 1, 0, L_RED, 1, 0, 0, 8001);
    apply(0, 1, 1, 0, L_GRN, 0, 1, 0, 8002);
    $display("disable from RED, re-enable with go: RED then GREEN");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
